seg7: RTL and testbench
=======================

# seg7

Memory-mapped four-digit seven-segment display driver on the CPU I/O bus, the output-side counterpart of the push-button input port. The CPU writes two data bytes (four hex digits) and one control byte at fixed addresses. The block time-multiplexes the digits onto shared, active-low segment and anode lines, with a guard interval between digits to suppress ghosting. Register contents can be read back over the same bus.

## Interface
- REFRESH_BITS, 12, scan counter width; each digit is selected for 2^REFRESH_BITS cycles.
- GUARD, 16, cycles at the start of each digit slot during which all anodes are off; must satisfy GUARD < 2^REFRESH_BITS.
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low; clock clk.
- addr  in  8  bus address.
- we  in  1  write strobe, sampled on rising clk.
- wdata  in  8  write data.
- out  out  8  read data; 0 when addr is not mapped to this block.
- seg  out  8  segments, active-low; bit7 = dp, bits6:0 = g,f,e,d,c,b,a.
- an  out  4  digit anodes, active-low; an[i] selects digit i (digit 0 is rightmost).

## Operation
- Registers, written when we=1 and addr matches:
  - 0xfc → dlo: digit1 = dlo[7:4], digit0 = dlo[3:0].
  - 0xfd → dhi: digit3 = dhi[7:4], digit2 = dhi[3:0].
  - 0xfe → ctrl: ctrl[7:4] = dp enable for digits 3..0; ctrl[3:0] = blank for digits 3..0 (1 = digit dark).
- Writes to any other address are ignored.
- Readback is combinational: out = dlo / dhi / ctrl for 0xfc / 0xfd / 0xfe; otherwise 8'h00. A read returns the register value as of the current cycle.
- Scan logic:
  - Free-running counter cnt (REFRESH_BITS wide) increments every cycle and wraps to 0.
  - 2-bit digit index idx advances 0→1→2→3→0 on the edge where cnt wraps from all-ones to 0.
- Registered outputs, updated every cycle from the current cnt, idx and registers:
  - If cnt < GUARD or ctrl[idx] = 1: an = 4'b1111, seg = 8'hff.
  - Otherwise: an = ~(4'b0001 << idx); seg[6:0] = hex(nibble[idx]); seg[7] = ~ctrl[4+idx].
- Hex table (seg[6:0]), digits 0..F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E.

## Timing
- Reset is synchronous. At the first rising edge with rst_n=0:
  - dlo = dhi = ctrl = 0, cnt = 0, idx = 0.
  - an = 4'b1111, seg = 8'hff.
- Reset asserted mid-scan or mid-write overrides everything at that edge; no write is committed.
- Write latency:
  - The register updates at edge N, where we is sampled high.
  - seg/an reflect the new value at edge N+1, if the current slot is active.
  - Readback shows the new value immediately after edge N.
- A write during an active slot changes seg at the next edge with no other disturbance. Anode sequencing is never affected by bus activity.
- Slot timing, after reset release at cycle 0 (cnt = 0):
  - Digit 0 slot covers cnt = 0 .. 2^REFRESH_BITS−1.
  - an is off through the edge where cnt = GUARD−1 is sampled, then on for the rest of the slot.
  - Full frame = 4·2^REFRESH_BITS cycles.
- Blanked digit: its slot keeps the normal duration but outputs an = 4'b1111 and seg = 8'hff for the whole slot.
- At most one an bit is low at any time. an transitions always pass through 4'b1111.

## Test plan
- Reset: hold rst_n=0 for 3 cycles, then release → an=4'b1111, seg=8'hff; out=0x00 at 0xfc/0xfd/0xfe.
- Write/readback (REFRESH_BITS=4, GUARD=2): write 0xfc←0x3A, 0xfd←0xF0, 0xfe←0x00 → reads return 3A, F0, 00; out=0x00 at 0xfb and 0xff.
- Scan sequence (same setup): observe 64 cycles →
  - Slot 0 (idx 0): an=1110, seg=0x88 (A), after 2 off-cycles at slot start.
  - Slot 1: an=1101, seg=0xB0 (3).
  - Slot 2: an=1011, seg=0xC0 (0).
  - Slot 3: an=0111, seg=0x8E (F).
  - Each slot lasts 16 cycles.
- Control: write 0xfe←0x24 → digit 2 always dark (an=1111 throughout its slot); digit 1 shows seg=0x30 (dp on, "3").
- Mid-slot write: during an active digit-0 slot, write 0xfc←0x35 → seg changes to 0x92 one cycle after the write edge; an unchanged.
- Reset mid-operation: assert rst_n=0 during slot 2 with a write strobe on the same edge → all registers 0, the write is not committed, an=1111; after release the scan restarts at digit 0.

Source files
------------

// File: rtl/seg7.sv
// rtl/seg7.sv - memory-mapped four-digit seven-segment display driver
//
// Purpose:
//   The CPU writes four hex digits (two bytes) and a control byte. The block
//   scans the digits onto shared active-low segment/anode lines. A guard
//   interval at the start of each digit slot keeps all anodes dark to
//   suppress ghosting. The registers can be read back combinationally.
//
// Parameters:
//   REFRESH_BITS  scan counter width; each digit slot lasts 2^REFRESH_BITS cycles
//   GUARD         dark cycles at the start of each slot (GUARD < 2^REFRESH_BITS)
//
// Ports:
//   clk    in   1  system clock
//   rst_n  in   1  synchronous active-low reset
//   addr   in   8  bus address (0xfc dlo, 0xfd dhi, 0xfe ctrl)
//   we     in   1  write strobe, sampled on rising clk
//   wdata  in   8  write data
//   out    out  8  read data, 0 for unmapped addresses
//   seg    out  8  segments, active-low; bit7 dp, bits6:0 g..a
//   an     out  4  anodes, active-low; an[0] is the rightmost digit

module seg7 #(
  parameter int REFRESH_BITS = 12,
  parameter int GUARD        = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] addr,
  input  logic       we,
  input  logic [7:0] wdata,
  output logic [7:0] out,
  output logic [7:0] seg,
  output logic [3:0] an
);

  localparam logic [7:0] ADDR_DLO  = 8'hfc;
  localparam logic [7:0] ADDR_DHI  = 8'hfd;
  localparam logic [7:0] ADDR_CTRL = 8'hfe;
  localparam logic [REFRESH_BITS-1:0] GUARD_CNT = REFRESH_BITS'(GUARD);

  logic [7:0]              r_dlo;
  logic [7:0]              r_dhi;
  logic [7:0]              r_ctrl;
  logic [REFRESH_BITS-1:0] r_cnt;
  logic [1:0]              r_idx;
  logic [7:0]              r_seg;
  logic [3:0]              r_an;

  logic                    w_cnt_wrap;
  logic [3:0]              w_nibble;
  logic                    w_dark;
  logic                    w_dp;
  logic [7:0]              w_seg_next;
  logic [3:0]              w_an_next;

  // Segment pattern for a hex digit, active-low, bits g..a.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'ha: hex7 = 7'h08;
      4'hb: hex7 = 7'h03;
      4'hc: hex7 = 7'h46;
      4'hd: hex7 = 7'h21;
      4'he: hex7 = 7'h06;
      default: hex7 = 7'h0e;
    endcase
  endfunction

  assign w_cnt_wrap = &r_cnt;

  always_comb begin
    w_nibble = r_dlo[3:0];
    case (r_idx)
      2'd0: w_nibble = r_dlo[3:0];
      2'd1: w_nibble = r_dlo[7:4];
      2'd2: w_nibble = r_dhi[3:0];
      default: w_nibble = r_dhi[7:4];
    endcase
  end

  // The guard window at every slot start also guarantees that an anode
  // change always passes through the all-off state.
  assign w_dark     = (r_cnt < GUARD_CNT) || r_ctrl[r_idx];
  assign w_dp       = r_ctrl[{1'b1, r_idx}];
  assign w_seg_next = w_dark ? 8'hff : {~w_dp, hex7(w_nibble)};
  assign w_an_next  = w_dark ? 4'b1111 : ~(4'b0001 << r_idx);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dlo  <= 8'h00;
      r_dhi  <= 8'h00;
      r_ctrl <= 8'h00;
      r_cnt  <= '0;
      r_idx  <= 2'd0;
      r_seg  <= 8'hff;
      r_an   <= 4'b1111;
    end else begin
      if (we) begin
        case (addr)
          ADDR_DLO:  r_dlo  <= wdata;
          ADDR_DHI:  r_dhi  <= wdata;
          ADDR_CTRL: r_ctrl <= wdata;
          default: ;
        endcase
      end
      r_cnt <= r_cnt + 1'b1;
      if (w_cnt_wrap) begin
        r_idx <= r_idx + 2'd1;
      end
      r_seg <= w_seg_next;
      r_an  <= w_an_next;
    end
  end

  always_comb begin
    out = 8'h00;
    case (addr)
      ADDR_DLO:  out = r_dlo;
      ADDR_DHI:  out = r_dhi;
      ADDR_CTRL: out = r_ctrl;
      default:   out = 8'h00;
    endcase
  end

  assign seg = r_seg;
  assign an  = r_an;

endmodule

// File: tb/tb_seg7.sv
// tb/tb_seg7.sv - self-checking bench for seg7 (REFRESH_BITS=4, GUARD=2)

module tb_seg7;

  logic       clk;
  logic       rst_n;
  logic [7:0] addr;
  logic       we;
  logic [7:0] wdata;
  logic [7:0] out;
  logic [7:0] seg;
  logic [3:0] an;

  int n_checks;
  int n_errors;

  typedef struct {
    logic [7:0] addr;
    logic       we;
    logic [7:0] wdata;
    logic [7:0] exp_out;
  } bus_vec_t;

  typedef struct {
    logic [3:0] exp_an;
    logic [7:0] exp_seg;
  } slot_vec_t;

  bus_vec_t  bus_vecs[8];
  slot_vec_t slot_vecs[4];

  seg7 #(.REFRESH_BITS(4), .GUARD(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .out   (out),
    .seg   (seg),
    .an    (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic wait_an(input logic [3:0] val, input int limit, input string name);
    int k;
    k = 0;
    while (an !== val && k < limit) begin
      tick();
      k++;
    end
    if (an !== val) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: timeout waiting for an=%b, got %b", name, val, an);
    end
  endtask

  // Aligns to the first active cycle of a digit-0 slot.
  task automatic wait_slot0(input string name);
    wait_an(4'b1111, 100, name);
    wait_an(4'b1110, 100, name);
  endtask

  // 16-cycle slots: 14 active cycles then the 2 guard cycles of the next slot.
  task automatic run_scan(input string name);
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 16; c++) begin
        if (c < 14) begin
          check($sformatf("%s_an_s%0d_c%0d", name, s, c), {4'h0, an}, {4'h0, slot_vecs[s].exp_an});
          check($sformatf("%s_seg_s%0d_c%0d", name, s, c), seg, slot_vecs[s].exp_seg);
        end else begin
          check($sformatf("%s_guard_an_s%0d_c%0d", name, s, c), {4'h0, an}, 8'h0f);
          check($sformatf("%s_guard_seg_s%0d_c%0d", name, s, c), seg, 8'hff);
        end
        tick();
      end
    end
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    addr = a; wdata = d; we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0; we = 1'b0; addr = 8'h00; wdata = 8'h00;

    bus_vecs[0] = '{8'hfc, 1'b1, 8'h3a, 8'h3a};
    bus_vecs[1] = '{8'hfd, 1'b1, 8'hf0, 8'hf0};
    bus_vecs[2] = '{8'hfe, 1'b1, 8'h00, 8'h00};
    bus_vecs[3] = '{8'hfb, 1'b1, 8'h77, 8'h00};
    bus_vecs[4] = '{8'hff, 1'b1, 8'h99, 8'h00};
    bus_vecs[5] = '{8'hfc, 1'b0, 8'h00, 8'h3a};
    bus_vecs[6] = '{8'hfd, 1'b0, 8'h11, 8'hf0};
    bus_vecs[7] = '{8'hfe, 1'b0, 8'h00, 8'h00};

    // Reset
    repeat (3) tick();
    check("reset_an", {4'h0, an}, 8'h0f);
    check("reset_seg", seg, 8'hff);
    rst_n = 1'b1;
    addr = 8'hfc; #1 check("reset_dlo", out, 8'h00);
    addr = 8'hfd; #1 check("reset_dhi", out, 8'h00);
    addr = 8'hfe; #1 check("reset_ctrl", out, 8'h00);

    // Write / readback table
    for (int i = 0; i < 8; i++) begin
      addr = bus_vecs[i].addr; we = bus_vecs[i].we; wdata = bus_vecs[i].wdata;
      tick();
      we = 1'b0;
      check($sformatf("bus_vec%0d_addr%02h", i, bus_vecs[i].addr), out, bus_vecs[i].exp_out);
    end

    // Scan sequence with digits F,0,3,A and no dp/blank
    slot_vecs[0] = '{4'b1110, 8'h88};
    slot_vecs[1] = '{4'b1101, 8'hb0};
    slot_vecs[2] = '{4'b1011, 8'hc0};
    slot_vecs[3] = '{4'b0111, 8'h8e};
    wait_slot0("scan_align");
    run_scan("scan");

    // Control: dp on digit 1, digit 2 blanked
    bus_write(8'hfe, 8'h24);
    addr = 8'hfe; #1 check("ctrl_readback", out, 8'h24);
    slot_vecs[1] = '{4'b1101, 8'h30};
    slot_vecs[2] = '{4'b1111, 8'hff};
    wait_slot0("ctrl_align");
    run_scan("ctrl");

    // Mid-slot write to digit 0
    wait_slot0("mid_align");
    tick();
    tick();
    check("mid_pre_seg", seg, 8'h88);
    addr = 8'hfc; wdata = 8'h35; we = 1'b1;
    tick();
    we = 1'b0;
    check("mid_edgeN_seg", seg, 8'h88);
    check("mid_edgeN_an", {4'h0, an}, 8'h0e);
    check("mid_edgeN_readback", out, 8'h35);
    tick();
    check("mid_edgeN1_seg", seg, 8'h92);
    check("mid_edgeN1_an", {4'h0, an}, 8'h0e);

    // Reset during slot 2 with a coincident write
    bus_write(8'hfe, 8'h00);
    wait_an(4'b1011, 100, "rst_align");
    rst_n = 1'b0; addr = 8'hfd; wdata = 8'h55; we = 1'b1;
    tick();
    we = 1'b0;
    check("rst_mid_an", {4'h0, an}, 8'h0f);
    check("rst_mid_seg", seg, 8'hff);
    addr = 8'hfd; #1 check("rst_mid_dhi", out, 8'h00);
    addr = 8'hfc; #1 check("rst_mid_dlo", out, 8'h00);
    addr = 8'hfe; #1 check("rst_mid_ctrl", out, 8'h00);
    rst_n = 1'b1;
    tick();
    check("rst_rel_guard0_an", {4'h0, an}, 8'h0f);
    tick();
    check("rst_rel_guard1_an", {4'h0, an}, 8'h0f);
    tick();
    check("rst_rel_digit0_an", {4'h0, an}, 8'h0e);
    check("rst_rel_digit0_seg", seg, 8'hc0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
